// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch unit: PC register, instruction-bus request
//               FSM, one-word fetch buffer and instruction register with
//               decoded field slices. Optional macro FETCH_MISALIGN_CHECK_EN
//               rejects misaligned jump targets and raises a sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic        load_ir,
    input  logic        en_pc,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        stall,
    output logic [31:0] ir,
    output logic [6:0]  opcode,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        fault
);

    localparam logic [31:0] C_NOP       = 32'h0000_0013;
    localparam logic [31:0] C_WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUF  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_buf;

    logic        w_ibus_req;
    logic        w_capture;
    logic        w_stall_bus;
    logic        w_ir_load;
    logic        w_pc_upd;
    logic [31:0] w_pc_plus4;

    // ------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM: next state and bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_ibus_req  = 1'b0;
        w_capture   = 1'b0;
        w_stall_bus = 1'b0;
        w_ir_load   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_req) begin
                    w_ibus_req = 1'b1;
                    if (ibus_ack) begin
                        w_capture = 1'b1;
                        w_next    = S_BUF;
                    end else begin
                        w_stall_bus = 1'b1;
                        w_next      = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_ibus_req = 1'b1;
                if (ibus_ack) begin
                    w_capture = 1'b1;
                    w_next    = S_BUF;
                end else begin
                    w_stall_bus = 1'b1;
                end
            end
            S_BUF: begin
                if (load_ir) begin
                    w_ir_load = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch buffer and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_buf <= 32'h0000_0000;
            r_ir  <= C_NOP;
        end else begin
            if (w_capture) begin
                r_buf <= ibus_rdata;
            end
            if (w_ir_load) begin
                r_ir <= r_buf;
            end
        end
    end

    // ------------------------------------------------------------------
    // Program counter; frozen while a bus request is outstanding so the
    // address presented to the bus stays stable.
    // ------------------------------------------------------------------
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_upd   = en_pc && (r_state != S_REQ);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;
    logic w_misalign;

    assign w_misalign = (pc_target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else if (w_pc_upd) begin
            if (pc_load) begin
                if (w_misalign) begin
                    r_fault <= 1'b1;
                end else begin
                    r_pc <= pc_target;
                end
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign fault = r_fault;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (w_pc_upd) begin
            if (pc_load) begin
                r_pc <= pc_target & C_WORD_MASK;
            end else begin
                r_pc <= w_pc_plus4;
            end
        end
    end

    assign fault = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ibus_req  = w_ibus_req;
    assign ibus_addr = r_pc & C_WORD_MASK;
    // A load_ir with nothing buffered must hold the control unit too.
    assign stall     = w_stall_bus | (load_ir && (r_state != S_BUF));

    assign ir      = r_ir;
    assign opcode  = r_ir[6:0];
    assign rd      = r_ir[11:7];
    assign f3      = r_ir[14:12];
    assign rs1     = r_ir[19:15];
    assign rs2     = r_ir[24:20];
    assign f7      = r_ir[31:25];

    assign pc      = r_pc;
    assign next_pc = w_pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch with a queue
//               scoreboard of fetched words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_req;
    logic        load_ir;
    logic        en_pc;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic        stall;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        fault;

    int          n_cmp;
    int          n_err;
    logic [31:0] sb_q[$];
    logic [31:0] r_ir_hold;
    logic [31:0] w_word;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_req  (fetch_req),
        .load_ir    (load_ir),
        .en_pc      (en_pc),
        .pc_load    (pc_load),
        .pc_target  (pc_target),
        .ibus_req   (ibus_req),
        .ibus_addr  (ibus_addr),
        .ibus_ack   (ibus_ack),
        .ibus_rdata (ibus_rdata),
        .stall      (stall),
        .ir         (ir),
        .opcode     (opcode),
        .f3         (f3),
        .f7         (f7),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .pc         (pc),
        .next_pc    (next_pc),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ir_from_sb(input string tag);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, ir, e);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        fetch_req  = 1'b0;
        load_ir    = 1'b0;
        en_pc      = 1'b0;
        pc_load    = 1'b0;
        pc_target  = 32'h0;
        ibus_ack   = 1'b0;
        ibus_rdata = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst_pc",    pc, 32'h0);
        chk("rst_ir",    ir, 32'h0000_0013);
        chk("rst_req",   {31'b0, ibus_req}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        rst = 1'b1;
        tick();
        chk("idle_req", {31'b0, ibus_req}, 32'h0);

        // Zero-wait fetch
        fetch_req  = 1'b1;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'h0050_0093;
        #1;
        chk("zw_req",   {31'b0, ibus_req}, 32'h1);
        chk("zw_addr",  ibus_addr, 32'h0);
        chk("zw_stall", {31'b0, stall}, 32'h0);
        sb_q.push_back(32'h0050_0093);
        tick();
        fetch_req = 1'b0;
        ibus_ack  = 1'b0;
        load_ir   = 1'b1;
        #1;
        chk("buf_stall", {31'b0, stall}, 32'h0);
        chk("buf_req",   {31'b0, ibus_req}, 32'h0);
        tick();
        load_ir = 1'b0;
        chk_ir_from_sb("zw_ir");
        chk("zw_opcode", {25'b0, opcode}, 32'h13);
        chk("zw_rd",     {27'b0, rd}, 32'h1);
        chk("zw_rs1",    {27'b0, rs1}, 32'h0);
        chk("zw_f3",     {29'b0, f3}, 32'h0);

        // load_ir without a buffered word
        r_ir_hold = ir;
        load_ir = 1'b1;
        #1;
        chk("nobuf_stall", {31'b0, stall}, 32'h1);
        tick();
        load_ir = 1'b0;
        chk("nobuf_ir", ir, r_ir_hold);

        // Sequential increment from IDLE
        en_pc = 1'b1;
        tick();
        en_pc = 1'b0;
        chk("inc_pc",     pc, 32'h4);
        chk("inc_nextpc", next_pc, 32'h8);

        // Fetch with ack three cycles late; en_pc in REQ must be ignored
        fetch_req = 1'b1;
        #1;
        chk("wait0_stall", {31'b0, stall}, 32'h1);
        chk("wait0_addr",  ibus_addr, 32'h4);
        tick();
        fetch_req = 1'b0;
        en_pc     = 1'b1;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("wait_stall", {31'b0, stall}, 32'h1);
            chk("wait_addr",  ibus_addr, 32'h4);
            chk("wait_req",   {31'b0, ibus_req}, 32'h1);
            tick();
        end
        en_pc      = 1'b0;
        w_word     = $urandom;
        ibus_ack   = 1'b1;
        ibus_rdata = w_word;
        #1;
        chk("ack_stall", {31'b0, stall}, 32'h0);
        sb_q.push_back(w_word);
        tick();
        chk("req_pc_held", pc, 32'h4);
        // Stray ack while buffered must not overwrite the word
        ibus_rdata = ~w_word;
        tick();
        ibus_ack = 1'b0;
        load_ir  = 1'b1;
        tick();
        load_ir = 1'b0;
        chk_ir_from_sb("late_ir");
        chk("late_rs2", {27'b0, rs2}, {27'b0, w_word[24:20]});
        chk("late_f7",  {25'b0, f7},  {25'b0, w_word[31:25]});

        // Jump then increment, and en_pc=0 ignores pc_load
        en_pc     = 1'b1;
        pc_load   = 1'b1;
        pc_target = 32'h0000_0100;
        tick();
        chk("jmp100", pc, 32'h100);
        pc_target = 32'h0000_0200;
        tick();
        chk("jmp200", pc, 32'h200);
        pc_load = 1'b0;
        tick();
        chk("inc204", pc, 32'h204);
        en_pc     = 1'b0;
        pc_load   = 1'b1;
        pc_target = 32'h0000_0300;
        tick();
        chk("hold204", pc, 32'h204);

        // Wrap-around
        en_pc     = 1'b1;
        pc_target = 32'hFFFF_FFFC;
        tick();
        pc_load = 1'b0;
        chk("top_next", next_pc, 32'h0);
        tick();
        en_pc = 1'b0;
        chk("wrap_pc",   pc, 32'h0);
        chk("wrap_next", next_pc, 32'h4);

        // Misaligned target
        en_pc     = 1'b1;
        pc_load   = 1'b1;
        pc_target = 32'h0000_0100;
        tick();
        pc_target = 32'h0000_0102;
        tick();
        en_pc   = 1'b0;
        pc_load = 1'b0;
        chk("mis_pc", pc, 32'h100);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_fault", {31'b0, fault}, 32'h1);
        tick();
        chk("mis_sticky", {31'b0, fault}, 32'h1);
`else
        chk("mis_fault", {31'b0, fault}, 32'h0);
`endif

        // Reset while a request is outstanding, then a late ack
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        chk("pre_rst_req", {31'b0, ibus_req}, 32'h1);
        rst = 1'b0;
        tick();
        rst        = 1'b1;
        ibus_ack   = 1'b1;
        ibus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rr_req",   {31'b0, ibus_req}, 32'h0);
        chk("rr_stall", {31'b0, stall}, 32'h0);
        tick();
        ibus_ack = 1'b0;
        chk("rr_pc",    pc, 32'h0);
        chk("rr_ir",    ir, 32'h0000_0013);
        chk("rr_fault", {31'b0, fault}, 32'h0);
        load_ir = 1'b1;
        #1;
        chk("rr_nobuf_stall", {31'b0, stall}, 32'h1);
        tick();
        load_ir = 1'b0;
        chk("rr_ir_kept", ir, 32'h0000_0013);

        chk("sb_drained", sb_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
